// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: byte-serial instruction fetch with big-endian word assembly,
// a small prefetch FIFO toward decode, and redirect/flush support.
// Optional build macro FETCH_STATS_EN adds saturating push/flush counters
// on the stat_words and stat_flushes outputs.
module inst_fetch_unit #(
  parameter int          IMEM_AW  = 5,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_rd_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [7:0]         imem_rdata,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [31:0]        inst_data,
  output logic [31:0]        inst_pc,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]        stat_words,
  output logic [15:0]        stat_flushes
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;   // PC of the word whose bytes are being requested
  logic [31:0]   word_pc_q, word_pc_d;     // PC of the word whose bytes are being assembled
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   asm_q, asm_d;
  logic          wif_q, wif_d;             // a word has been requested but not yet pushed
  logic          tag_q, tag_d;             // stream tag, toggled on every redirect
  logic          rd_pend_q;                // a byte returns this cycle
  logic          rd_tag_q;
  logic [1:0]    rd_idx_q;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   head_data_q, head_data_d;
  logic [31:0]   head_pc_q, head_pc_d;
  logic [31:0]   mem_data_q [DEPTH];
  logic [31:0]   mem_pc_q   [DEPTH];

  logic          room;
  logic          issue;
  logic          wif_set;
  logic          rsp_ok;
  logic          push;
  logic          pop;
  logic [31:0]   push_data;
  logic [CW-1:0] count_after_pop;
  logic          unused_bits;

  // The low two redirect bits are forced to zero, so they are deliberately unused.
  assign unused_bits = ^redirect_pc[1:0];

  // Room for one more word counting the word already on its way.
  assign room = ({1'b0, count_q} + {{CW{1'b0}}, wif_q}) < (CW + 1)'(DEPTH);

  // Fetch sequencer: request generation and next-state selection; redirect overrides.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    fetch_pc_d = fetch_pc_q;
    word_pc_d  = word_pc_q;
    issue      = 1'b0;
    wif_set    = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (idx_q == 2'd0) begin
          if (room) begin
            issue     = 1'b1;
            wif_set   = 1'b1;
            word_pc_d = fetch_pc_q;
            idx_d     = 2'd1;
          end else begin
            state_d = STALL;
          end
        end else begin
          issue = 1'b1;
          idx_d = idx_q + 2'd1;
          // Advance once the last byte of this word is requested so the
          // next idx-0 request can overlap the idx-3 return.
          if (idx_q == 2'd3) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end
      end
      STALL: begin
        if (room) begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redirect_valid) begin
      state_d    = FETCH;
      idx_d      = 2'd0;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end
  end

  assign imem_rd_en = issue;
  assign imem_addr  = issue ? (fetch_pc_q[IMEM_AW-1:0] + IMEM_AW'(idx_q)) : '0;

  // Byte assembly and push generation; bytes from a flushed stream are rejected by tag.
  always_comb begin
    rsp_ok    = rd_pend_q && (rd_tag_q == tag_q);
    asm_d     = asm_q;
    push      = 1'b0;
    push_data = {asm_q[31:8], imem_rdata};
    if (rsp_ok) begin
      case (rd_idx_q)
        2'd0: asm_d[31:24] = imem_rdata;
        2'd1: asm_d[23:16] = imem_rdata;
        2'd2: asm_d[15:8]  = imem_rdata;
        default: begin
          asm_d[7:0] = imem_rdata;
          push       = 1'b1;
        end
      endcase
    end
    if (redirect_valid) begin
      asm_d = '0;
      push  = 1'b0;
    end
  end

  assign pop        = inst_valid && inst_ready && !redirect_valid;
  assign inst_valid = (count_q != '0);
  assign inst_data  = head_data_q;
  assign inst_pc    = head_pc_q;

  // FIFO bookkeeping and head-register refill.
  always_comb begin
    tag_d           = tag_q ^ redirect_valid;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    count_d         = count_q;
    count_after_pop = pop ? (count_q - CW'(1)) : count_q;
    head_data_d     = head_data_q;
    head_pc_d       = head_pc_q;
    if (wif_set) begin
      wif_d = 1'b1;
    end else if (push) begin
      wif_d = 1'b0;
    end else begin
      wif_d = wif_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (redirect_valid) begin
      wif_d    = 1'b0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (count_d != '0) begin
      // An empty FIFO hands the freshly pushed word straight to the head.
      if (push && (count_after_pop == '0)) begin
        head_data_d = push_data;
        head_pc_d   = word_pc_q;
      end else begin
        head_data_d = mem_data_q[rd_ptr_d];
        head_pc_d   = mem_pc_q[rd_ptr_d];
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      word_pc_q   <= RESET_PC;
      idx_q       <= 2'd0;
      asm_q       <= '0;
      wif_q       <= 1'b0;
      tag_q       <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_tag_q    <= 1'b0;
      rd_idx_q    <= 2'd0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      head_data_q <= '0;
      head_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      word_pc_q   <= word_pc_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      wif_q       <= wif_d;
      tag_q       <= tag_d;
      rd_pend_q   <= issue;
      rd_tag_q    <= tag_q;
      rd_idx_q    <= idx_q;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      head_data_q <= head_data_d;
      head_pc_q   <= head_pc_d;
    end
  end

  // FIFO storage writes (no reset needed; occupancy is tracked by count_q).
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_data_q[wr_ptr_q] <= push_data;
      mem_pc_q[wr_ptr_q]   <= word_pc_q;
    end
  end

  // The issue gate reserves space for the word in flight, so a push never finds the FIFO full.
  no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count_q == CW'(DEPTH))));

`ifdef FETCH_STATS_EN
  logic [15:0] stat_words_q;
  logic [15:0] stat_flushes_q;

  // Saturating counters of pushed words and redirect cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_words_q   <= '0;
      stat_flushes_q <= '0;
    end else begin
      if (push && (stat_words_q != 16'hFFFF)) begin
        stat_words_q <= stat_words_q + 16'd1;
      end
      if (redirect_valid && (stat_flushes_q != 16'hFFFF)) begin
        stat_flushes_q <= stat_flushes_q + 16'd1;
      end
    end
  end

  assign stat_words   = stat_words_q;
  assign stat_flushes = stat_flushes_q;
`endif

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Fetch stage directly upstream of the single-cycle core.
- Reads the byte-wide instruction memory one byte per cycle and assembles big-endian 32-bit instructions: byte at addr is bits [31:24], addr+3 is bits [7:0].
- Queues assembled words with their PC in a small prefetch FIFO and presents them to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute, which flush all fetched state and restart fetch at the new PC.

Parameters:
- IMEM_AW, 5, instruction-memory byte-address width; the memory holds 32 bytes and fetch addresses wrap modulo 2^IMEM_AW.
- DEPTH, 4, prefetch FIFO depth in words; must be a power of two, 2..16.
- RESET_PC, 32'h0, PC of the first instruction fetched after reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- imem_rd_en  out  1  byte read request this cycle.
- imem_addr  out  IMEM_AW  byte address of the request, equal to fetch_pc[IMEM_AW-1:0] plus byte index.
- imem_rdata  in  8  read byte, valid exactly one cycle after imem_rd_en.
- inst_valid  out  1  FIFO head holds an instruction.
- inst_ready  in  1  decode accepts the head this cycle.
- inst_data  out  32  head instruction word.
- inst_pc  out  32  full 32-bit PC of the head word; does not wrap.
- redirect_valid  in  1  flush request and new PC.
- redirect_pc  in  32  target PC; bits [1:0] are ignored and treated as 0.

Behaviour:
- Reset: one clock; reset is synchronous and active-low. While rst_n is low at a posedge:
  - state goes to IDLE, fetch_pc = RESET_PC, byte index = 0, FIFO count = 0.
  - Outputs: inst_valid=0, imem_rd_en=0, imem_addr=0, inst_data=0, inst_pc=0.
  - A reset mid-word or mid-stream drops everything; any imem_rdata returned in the following cycle is ignored.
- States:
  - IDLE: entered on reset. Moves to FETCH on the first cycle with rst_n high. No request is issued in IDLE.
  - FETCH: issues one byte read per cycle, byte index 0..3, with imem_addr = fetch_pc[IMEM_AW-1:0] + idx (modulo 2^IMEM_AW).
    - The read for idx 0 is issued only if (count + word_in_flight) < DEPTH. Otherwise the unit moves to STALL.
  - STALL: imem_rd_en=0. Returns to FETCH in the cycle after room exists.
- Assembly:
  - The byte returned for idx k is shifted into the assembly register at bits [31-8k -: 8].
  - When the idx-3 byte returns, {word, fetch_pc} is pushed into the FIFO and fetch_pc += 4.
  - Latency from the first request to inst_valid=1 is 5 cycles.
  - Steady-state throughput is one word per 4 cycles; the next word's idx-0 request overlaps the previous idx-3 return.
- FIFO:
  - A pop occurs when inst_valid && inst_ready.
  - Push and pop in the same cycle leaves count unchanged.
  - The FIFO never overflows by construction; a push while full is a design error and is asserted in simulation.
- Outputs:
  - inst_data and inst_pc are driven from the FIFO head register and hold stable while inst_valid && !inst_ready.
  - When empty: inst_valid=0 and data holds its last value.
- Redirect (highest priority):
  - Effect at the same posedge: FIFO count = 0, idx = 0, assembly discarded, fetch_pc = {redirect_pc[31:2], 2'b00}, state = FETCH.
  - The byte returning in the next cycle belongs to the old stream and is discarded; a one-bit tag is toggled per redirect to reject it.
  - A pop, or a word completing, in the same cycle as a redirect is cancelled.
  - inst_valid is 0 in the cycle after a redirect.
  - Back-to-back redirects: the last one wins.
- Wrap: fetch_pc increments as a full 32 bits. Only the address wraps, so PC 0x1C is followed by imem_addr 0x00 with inst_pc 0x20.

Optional Feature:
- Macro: FETCH_STATS_EN.
- When defined, adds two outputs: stat_words (out, 16) and stat_flushes (out, 16).
  - stat_words increments on each FIFO push.
  - stat_flushes increments on each cycle with redirect_valid=1.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined, neither port nor any counter logic exists.

Test Plan:
- Basic fetch: imem bytes 0..3 = 20,13,00,05; rst_n released, inst_ready=1 -> 5 cycles later inst_valid=1, inst_data=0x20130005, inst_pc=0x0; next word 4 cycles later with inst_pc=0x4.
- Backpressure: DEPTH=4, inst_ready=0 -> after 4 pushes imem_rd_en stays 0 and the head stays inst_pc=0x0; raise inst_ready for 1 cycle -> head becomes 0x4 and fetch resumes the following cycle.
- Mid-word redirect: redirect_pc=0x12 asserted on the cycle idx 2 returns -> partial word dropped, next request addr=0x10, first delivered inst_pc=0x10, no word from the old stream appears.
- Redirect with pop and push colliding: FIFO holds 2 words, inst_ready=1 and a word completes in the same cycle as redirect_pc=0x8 -> count=0, inst_valid=0 next cycle, next delivered inst_pc=0x8.
- Wrap: redirect_pc=0x1C -> words delivered with inst_pc 0x1C, 0x20, 0x24 from addresses 0x1C, 0x00, 0x04.
- Reset mid-stream plus stats: FETCH_STATS_EN defined, 3 pushes and 1 redirect -> stat_words=3, stat_flushes=1; rst_n low for 1 cycle during idx 1 -> both stats 0, inst_valid=0, restart at RESET_PC.
